alu_operand_sequencer: RTL and testbench
========================================

# alu_operand_sequencer

Sequential front end for the combinational 4-function ALU: it loads operand A, operand B and the 4-bit operation code one at a time from a shared switch bus, driven by successive presses of a load button. It presents these values to the ALU and registers the ALU result one cycle later. It also computes and registers the N/Z/C/V flags, which the ALU itself does not drive. The block sits between the board I/O (switches/buttons) and the ALU, and feeds the display logic.

## Interface

Parameters:
- BITS, 4, operand/result width (≥2)

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- data_in  in  BITS  operand source (switches)
- code_in  in  4  operation code source (switches)
- load  in  1  debounced button level; each rising edge advances one step
- clear  in  1  synchronous abort; returns to WAIT_A and zeroes registers
- alu_a  out  BITS  registered operand A to ALU
- alu_b  out  BITS  registered operand B to ALU
- alu_code  out  4  registered operation code to ALU
- alu_result  in  BITS  combinational result from ALU
- result_q  out  BITS  registered result
- flags_q  out  4  registered flags {N,Z,C,V} (bit3..bit0)
- state  out  3  current FSM state encoding, for LEDs
- result_valid  out  1  high while in DONE

## Operation

- Edge detect: `load_d` <= load on every cycle, reset value 0. `step = load & ~load_d`. Holding load high yields exactly one step.
- FSM states and encodings: WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, DONE=4. Other encodings go to WAIT_A.
  - WAIT_A: on step, alu_a <= data_in, then go to WAIT_B.
  - WAIT_B: on step, alu_b <= data_in, then go to WAIT_OP.
  - WAIT_OP: on step, alu_code <= code_in, then go to EXEC.
  - EXEC: unconditional, lasts exactly one cycle. result_q <= alu_result and flags_q <= computed flags, then go to DONE. A step during EXEC is ignored.
  - DONE: result_valid=1. On step, go to WAIT_A. result_q and flags_q hold their values until the next EXEC. Operands are not cleared.
- clear takes priority over step in every state. On clear: state=WAIT_A, and alu_a, alu_b, alu_code, result_q and flags_q all go to 0.
- Flags are computed from alu_a, alu_b and alu_code, with R = alu_result:
  - N = R[BITS-1]; Z = (R == 0).
  - 0000 add: C = carry out of the BITS+1-bit sum. V = (A[msb]==B[msb]) & (R[msb]!=A[msb]).
  - 0001 sub: C = 1 when A ≥ B unsigned (no borrow). V = (A[msb]!=B[msb]) & (R[msb]!=A[msb]).
  - 0100 shift left: C = A[BITS-1], V = 0.
  - 0101 shift right: C = A[0], V = 0.
  - 1000/1001/1010, and any undefined code (the ALU performs OR for these): C = 0, V = 0.

## Timing

- Reset values: state=WAIT_A, alu_a=0, alu_b=0, alu_code=0, result_q=0, flags_q=0, result_valid=0, load_d=0.
- A step sampled at edge n is captured at edge n, and the state changes at edge n.
- Latency: the op-code step at edge n → EXEC during cycle n..n+1 → result_q/flags_q/result_valid valid after edge n+1. This is 2 clock edges from the op-code step.
- The ALU is combinational. alu_result must settle within one cycle of alu_code updating, and is sampled only in EXEC.
- If reset is asserted mid-sequence, all outputs go to their reset values immediately, regardless of clk. Deasserting reset with load held high does not generate a step until load falls and rises again.
- If clear and step occur in the same cycle, clear wins and the step is discarded.

## Test plan

- BITS=4, add: A=0111, B=0001, code=0000 → result_q=1000, flags_q=1001, result_valid high exactly 2 edges after the op-code step.
- Sub: A=0011, B=0011, code=0001 → result_q=0000, flags_q=0110. Then A=0001, B=0010 → result_q=1111, flags_q=1000.
- Shift left: A=1001, code=0100 → result_q=0010, flags_q=0010. Shift right: A=0011, code=0101 → result_q=0001, flags_q=0010.
- Undefined code 0011 with A=0101, B=0010 → result_q=0111, flags_q=0000. load held high for 10 cycles in WAIT_A advances only to WAIT_B.
- clear asserted in WAIT_OP together with a step → state=0, all registers 0, result_valid=0. Async rst pulse mid-EXEC (between edges) → outputs zero immediately and the next state is WAIT_A.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// -----------------------------------------------------------------------------
// alu_operand_sequencer
//
// Front end for the combinational 4-function ALU. Successive presses of the
// load button capture operand A, operand B and the operation code from the
// switch bus. The block then spends one cycle in EXEC, where it registers the
// ALU result together with the N/Z/C/V flags, and holds them in DONE until the
// next press.
//
// Ports
//   clk          rising-edge system clock
//   rst          asynchronous, active-high reset
//   data_in      operand source (switches), BITS wide
//   code_in      operation code source (switches), 4 bits
//   load         debounced button level; each rising edge is one step
//   clear        synchronous abort back to WAIT_A with registers zeroed
//   alu_a/alu_b  registered operands driven to the ALU
//   alu_code     registered operation code driven to the ALU
//   alu_result   combinational ALU result, sampled only in EXEC
//   result_q     registered result
//   flags_q      registered flags {N,Z,C,V}
//   state        current FSM encoding, for LEDs
//   result_valid high while in DONE
// -----------------------------------------------------------------------------
module alu_operand_sequencer #(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] data_in,
  input  logic [3:0]      code_in,
  input  logic            load,
  input  logic            clear,
  output logic [BITS-1:0] alu_a,
  output logic [BITS-1:0] alu_b,
  output logic [3:0]      alu_code,
  input  logic [BITS-1:0] alu_result,
  output logic [BITS-1:0] result_q,
  output logic [3:0]      flags_q,
  output logic [2:0]      state,
  output logic            result_valid
);

  localparam int MSB = BITS - 1;

  localparam logic [2:0] WAIT_A  = 3'd0;
  localparam logic [2:0] WAIT_B  = 3'd1;
  localparam logic [2:0] WAIT_OP = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SHL = 4'b0100;
  localparam logic [3:0] OP_SHR = 4'b0101;

  logic load_d;
  logic armed;
  logic step;

  // Flags {N,Z,C,V} for the current operands and the ALU result.
  function automatic logic [3:0] calc_flags(input logic [BITS-1:0] a,
                                            input logic [BITS-1:0] b,
                                            input logic [3:0]      code,
                                            input logic [BITS-1:0] r);
    logic [BITS:0] sum;
    logic          n;
    logic          z;
    logic          c;
    logic          v;
    sum = {1'b0, a} + {1'b0, b};
    n   = r[MSB];
    z   = (r == '0);
    c   = 1'b0;
    v   = 1'b0;
    case (code)
      OP_ADD: begin
        c = sum[BITS];
        v = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
      end
      OP_SUB: begin
        c = (a >= b);
        v = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
      end
      OP_SHL: c = a[MSB];
      OP_SHR: c = a[0];
      default: begin
        c = 1'b0;
        v = 1'b0;
      end
    endcase
    return {n, z, c, v};
  endfunction

  // A step needs a low sample of load since reset, so releasing reset while
  // the button is still held does not count as a press. load_d itself still
  // resets to 0; 'armed' carries the "seen low" condition.
  assign step = load & ~load_d & armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_d <= 1'b0;
      armed  <= 1'b0;
    end else begin
      load_d <= load;
      if (!load) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WAIT_A;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_code <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else if (clear) begin
      state    <= WAIT_A;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_code <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state)
        WAIT_A: if (step) begin
          alu_a <= data_in;
          state <= WAIT_B;
        end
        WAIT_B: if (step) begin
          alu_b <= data_in;
          state <= WAIT_OP;
        end
        WAIT_OP: if (step) begin
          alu_code <= code_in;
          state    <= EXEC;
        end
        // alu_code was registered on the previous edge, so alu_result has
        // had a full cycle to settle; any press here is ignored.
        EXEC: begin
          result_q <= alu_result;
          flags_q  <= calc_flags(alu_a, alu_b, alu_code, alu_result);
          state    <= DONE;
        end
        DONE: if (step) state <= WAIT_A;
        default: state <= WAIT_A;
      endcase
    end
  end

  assign result_valid = (state == DONE);

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;

  localparam int BITS = 4;

  logic            clk;
  logic            rst;
  logic [BITS-1:0] data_in;
  logic [3:0]      code_in;
  logic            load;
  logic            clear;
  logic [BITS-1:0] alu_a;
  logic [BITS-1:0] alu_b;
  logic [3:0]      alu_code;
  logic [BITS-1:0] alu_result;
  logic [BITS-1:0] result_q;
  logic [3:0]      flags_q;
  logic [2:0]      state;
  logic            result_valid;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  alu_operand_sequencer #(.BITS(BITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .code_in      (code_in),
    .load         (load),
    .clear        (clear),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_code     (alu_code),
    .alu_result   (alu_result),
    .result_q     (result_q),
    .flags_q      (flags_q),
    .state        (state),
    .result_valid (result_valid)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // ALU behaviour in plain integer arithmetic, results in [0, 2^BITS).
  function automatic int ref_alu(input int ua, input int ub, input logic [3:0] code);
    int full;
    full = 1 << BITS;
    case (code)
      4'b0000: return (ua + ub) % full;
      4'b0001: return (ua - ub + full) % full;
      4'b0100: return (ua * 2) % full;
      4'b0101: return ua / 2;
      4'b1000: return ua & ub;
      4'b1010: return ua ^ ub;
      default: return ua | ub;
    endcase
  endfunction

  // Flags from signed/unsigned range reasoning rather than bit formulas.
  function automatic logic [3:0] ref_flags(input int ua, input int ub, input logic [3:0] code);
    int full, half, sa, sb, r, t;
    logic n, z, c, v;
    full = 1 << BITS;
    half = full / 2;
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    r  = ref_alu(ua, ub, code);
    n  = (r >= half);
    z  = (r == 0);
    c  = 0;
    v  = 0;
    case (code)
      4'b0000: begin
        c = (ua + ub) >= full;
        t = sa + sb;
        v = (t >= half) || (t < -half);
      end
      4'b0001: begin
        c = (ua >= ub);
        t = sa - sb;
        v = (t >= half) || (t < -half);
      end
      4'b0100: c = (ua * 2) >= full;
      4'b0101: c = (ua % 2) == 1;
      default: c = 0;
    endcase
    return {n, z, c, v};
  endfunction

  // Environment ALU driven from the DUT's registered operands.
  assign alu_result = BITS'(ref_alu(int'(alu_a), int'(alu_b), alu_code));

  // Reference model: which step of the sequence we are in and what has been
  // captured so far.
  int              m_phase;
  logic [BITS-1:0] m_a, m_b, m_r;
  logic [3:0]      m_code, m_f;
  logic            m_prev_load;
  logic            m_press;

  assign m_press = load & ~m_prev_load;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_a <= '0; m_b <= '0; m_code <= '0; m_r <= '0; m_f <= '0;
      m_prev_load <= 1'b1;
    end else begin
      m_prev_load <= load;
      if (clear) begin
        m_phase <= 0; m_a <= '0; m_b <= '0; m_code <= '0; m_r <= '0; m_f <= '0;
      end else if (m_phase == 3) begin
        m_r     <= BITS'(ref_alu(int'(m_a), int'(m_b), m_code));
        m_f     <= ref_flags(int'(m_a), int'(m_b), m_code);
        m_phase <= 4;
      end else if (m_press) begin
        if (m_phase == 0) m_a <= data_in;
        if (m_phase == 1) m_b <= data_in;
        if (m_phase == 2) m_code <= code_in;
        m_phase <= (m_phase == 4) ? 0 : m_phase + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("state", 32'(state), 32'(m_phase));
      chk("valid", 32'(result_valid), 32'(m_phase == 4));
      chk("operands", {16'd0, alu_a, alu_b, alu_code}, {16'd0, m_a, m_b, m_code});
      chk("result/flags", {20'd0, result_q, flags_q}, {20'd0, m_r, m_f});
    end
  end

  task automatic press(input logic [BITS-1:0] d, input logic [3:0] c);
    data_in = d; code_in = c; load = 1;
    @(posedge clk); #2 load = 0;
    @(posedge clk); #2;
  endtask

  task automatic run_op(input string tag, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                        input logic [3:0] code, input logic [BITS-1:0] er, input logic [3:0] ef);
    press(a, 4'd0);
    press(b, 4'd0);
    data_in = '0; code_in = code; load = 1;
    @(posedge clk); #2;
    chk({tag, " exec state"}, 32'(state), 32'd3);
    chk({tag, " valid early"}, 32'(result_valid), 32'd0);
    load = 0;
    @(posedge clk); #2;
    chk({tag, " valid"}, 32'(result_valid), 32'd1);
    chk({tag, " result"}, 32'(result_q), 32'(er));
    chk({tag, " flags"}, 32'(flags_q), 32'(ef));
    press('0, 4'd0);
    chk({tag, " back to A"}, 32'(state), 32'd0);
    chk({tag, " result held"}, 32'(result_q), 32'(er));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; load = 0; clear = 0; data_in = '0; code_in = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset outputs", {alu_a, alu_b, alu_code, result_q, flags_q, state, result_valid},
        32'd0);
    rst = 0;
    chk_en = 1;
    @(posedge clk); #2;

    // Hand-computed cases pinning both DUT and model.
    run_op("add",  4'b0111, 4'b0001, 4'b0000, 4'b1000, 4'b1001);
    run_op("sub0", 4'b0011, 4'b0011, 4'b0001, 4'b0000, 4'b0110);
    run_op("subn", 4'b0001, 4'b0010, 4'b0001, 4'b1111, 4'b1000);
    run_op("shl",  4'b1001, 4'b0000, 4'b0100, 4'b0010, 4'b0010);
    run_op("shr",  4'b0011, 4'b0000, 4'b0101, 4'b0001, 4'b0010);
    run_op("undef", 4'b0101, 4'b0010, 4'b0011, 4'b0111, 4'b0000);

    // Holding load high yields exactly one step.
    data_in = 4'b1010; load = 1;
    repeat (10) @(posedge clk);
    #2;
    chk("hold load state", 32'(state), 32'd1);
    chk("hold load alu_a", 32'(alu_a), 32'hA);
    load = 0;
    @(posedge clk); #2;
    press(4'b0110, 4'd0);

    // Clear together with a step in WAIT_OP.
    chk("pre-clear state", 32'(state), 32'd2);
    code_in = 4'b0000; load = 1; clear = 1;
    @(posedge clk); #2;
    chk("clear state", 32'(state), 32'd0);
    chk("clear regs", {alu_a, alu_b, alu_code, result_q, flags_q, result_valid}, 32'd0);
    clear = 0; load = 0;
    @(posedge clk); #2;

    // Asynchronous reset between edges during EXEC.
    press(4'b0011, 4'd0);
    press(4'b0100, 4'd0);
    code_in = 4'b0000; load = 1;
    @(posedge clk); #2;
    chk("pre-rst exec", 32'(state), 32'd3);
    load = 0; rst = 1;
    #1;
    chk("async rst outputs", {alu_a, alu_b, alu_code, result_q, flags_q, state, result_valid},
        32'd0);
    #1 rst = 0;
    @(posedge clk); #2;
    chk("after rst state", 32'(state), 32'd0);

    // Releasing reset with load held does not step.
    rst = 1; load = 1; data_in = 4'b1111;
    @(posedge clk); #2 rst = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst load held", 32'(state), 32'd0);
    load = 0;
    @(posedge clk); #2;
    press(4'b1111, 4'd0);
    chk("press after release", 32'(state), 32'd1);

    // Random traffic checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      data_in = BITS'($urandom);
      code_in = 4'($urandom);
      load    = ($urandom_range(0, 2) == 0);
      clear   = ($urandom_range(0, 40) == 0);
    end
    clear = 0; load = 0;
    @(posedge clk); #2;
    @(negedge clk);
    chk_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
